// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one start/done fixed-point divider among NUM_REQ
// requesters, with a zero-denominator bypass and a watchdog on hung divides.
module divider_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ID_W      = 2,
  parameter int NUM_WIDTH = 17,
  parameter int DEN_WIDTH = 9,
  parameter int OUT_WIDTH = 17,
  parameter int TIMEOUT   = 64
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*NUM_WIDTH-1:0]   req_num,
  input  logic [NUM_REQ*DEN_WIDTH-1:0]   req_den,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_W-1:0]                resp_id,
  output logic [OUT_WIDTH-1:0]           resp_quotient,
  output logic                           resp_err,
  output logic                           div_start,
  output logic [NUM_WIDTH-1:0]           div_numerator,
  output logic [DEN_WIDTH-1:0]           div_denominator,
  input  logic [OUT_WIDTH-1:0]           div_quotient,
  input  logic                           div_done
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_ZERO   = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [2:0]           state_q,  state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q,     id_d;
  logic [WD_W-1:0]      wd_q,     wd_d;
  logic [NUM_WIDTH-1:0] num_q,    num_d;
  logic [DEN_WIDTH-1:0] den_q,    den_d;
  logic [OUT_WIDTH-1:0] quo_q,    quo_d;
  logic                 err_q,    err_d;

  logic [NUM_REQ-1:0][NUM_WIDTH-1:0] num_arr;
  logic [NUM_REQ-1:0][DEN_WIDTH-1:0] den_arr;
  assign num_arr = req_num;
  assign den_arr = req_den;

  // Lowest valid index at/above rr_ptr wins; otherwise wrap to the lowest valid index.
  logic            hi_found, lo_found, gnt_found;
  logic [ID_W-1:0] hi_idx, lo_idx, gnt_idx;

  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
  end

  assign gnt_found = lo_found;
  assign gnt_idx   = hi_found ? hi_idx : lo_idx;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    wd_d     = wd_q;
    num_d    = num_q;
    den_d    = den_q;
    quo_d    = quo_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          id_d     = gnt_idx;
          num_d    = num_arr[gnt_idx];
          den_d    = den_arr[gnt_idx];
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
          state_d  = (den_arr[gnt_idx] == '0) ? S_ZERO : S_ISSUE;
        end
      end
      S_ISSUE:  state_d = S_LAUNCH;
      // Guard cycle: a done left high by the previous op must not complete this one.
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wd_d = wd_q + WD_W'(1);
        if (div_done) begin
          quo_d   = div_quotient;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wd_q + WD_W'(1) == WD_W'(TIMEOUT)) begin
          quo_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_ZERO: begin
        quo_d   = num_q[NUM_WIDTH-1] ? SAT_NEG : SAT_POS;
        err_d   = 1'b1;
        state_d = S_RESP;
      end
      S_RESP:   if (resp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      wd_q     <= '0;
      num_q    <= '0;
      den_q    <= '0;
      quo_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      wd_q     <= wd_d;
      num_q    <= num_d;
      den_q    <= den_d;
      quo_q    <= quo_d;
      err_q    <= err_d;
    end
  end

  // Accept strobe is combinational so a request dropped before its edge is never latched.
  assign req_ready       = (state_q == S_IDLE && gnt_found && reset_n) ?
                           (NUM_REQ'(1) << gnt_idx) : '0;
  assign div_start       = (state_q == S_ISSUE);
  assign resp_valid      = (state_q == S_RESP);
  assign resp_id         = id_q;
  assign resp_quotient   = quo_q;
  assign resp_err        = err_q;
  assign div_numerator   = num_q;
  assign div_denominator = den_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus randomized rounds scored against a
// round-robin / saturating-divide reference model; includes a behavioural divider.
module tb_divider_arbiter;
  localparam int NR = 4, NW = 17, DW = 9, OW = 17, TO = 64, LAT = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid;
  logic [NR*NW-1:0]  req_num;
  logic [NR*DW-1:0]  req_den;
  logic [NR-1:0]     req_ready;
  logic              resp_valid, resp_ready;
  logic [1:0]        resp_id;
  logic [OW-1:0]     resp_quotient;
  logic              resp_err, div_start;
  logic [NW-1:0]     div_numerator;
  logic [DW-1:0]     div_denominator;
  logic [OW-1:0]     div_quotient = '0;
  logic              div_done = 1'b0;

  int checks = 0, errors = 0;
  int mode = 0;  // 0 normal, 1 never done, 2 done stays high after completing

  divider_arbiter #(.NUM_REQ(NR), .ID_W(2), .NUM_WIDTH(NW), .DEN_WIDTH(DW),
                    .OUT_WIDTH(OW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_num(req_num),
    .req_den(req_den), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_quotient(resp_quotient),
    .resp_err(resp_err), .div_start(div_start), .div_numerator(div_numerator),
    .div_denominator(div_denominator), .div_quotient(div_quotient), .div_done(div_done)
  );

  always #5 clk = ~clk;

  // Behavioural divider with fixed latency
  logic [NW-1:0] pn = '0;
  logic [DW-1:0] pd = '0;
  int cnt = 0;
  always @(posedge clk) begin
    if (div_start) begin
      pn <= div_numerator; pd <= div_denominator; cnt <= LAT;
      if (mode != 2) div_done <= 1'b0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      div_done <= 1'b0;
      if (cnt == 1 && mode != 1) begin
        div_done     <= 1'b1;
        div_quotient <= (pd == '0) ? '0 : OW'(int'($signed(pn)) / int'($signed(pd)));
      end
    end else if (mode != 2) div_done <= 1'b0;
  end

  function automatic logic [OW-1:0] ref_quot(input logic [NW-1:0] n, input logic [DW-1:0] d);
    int ni, di;
    if (d == '0) return n[NW-1] ? 17'h10000 : 17'h0FFFF;
    ni = int'($signed(n));
    di = int'($signed(d));
    return OW'(ni / di);
  endfunction

  task automatic put_req(input int i, input logic [NW-1:0] n, input logic [DW-1:0] d);
    req_num[i*NW +: NW] = n;
    req_den[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_resp(input int maxc, output int cyc, output int starts,
                           output int start_cyc, output int grants, output logic [NR-1:0] gmask);
    logic [NR-1:0] r;
    cyc = 0; starts = 0; start_cyc = 0; grants = 0; gmask = '0;
    while (!resp_valid && cyc < maxc) begin
      @(negedge clk);
      cyc++;
      if (div_start) begin starts++; start_cyc = cyc; end
      if (req_ready != '0) begin
        grants++; gmask |= req_ready; r = req_ready;
        @(posedge clk); #1;
        req_valid &= ~r;
      end
    end
  endtask

  task automatic ack();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req_valid = '0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) put_req(i, NW'(100 + i), DW'(3));
    @(negedge clk); @(negedge clk);
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    checks++; if ({resp_valid, div_start, resp_err} !== 3'b000) begin errors++;
      $display("FAIL reset_flags got %b exp 000", {resp_valid, div_start, resp_err}); end
    checks++; if ({resp_id, resp_quotient, div_numerator, div_denominator} !== '0) begin errors++;
      $display("FAIL reset_data got %h/%h/%h/%h exp 0", resp_id, resp_quotient, div_numerator, div_denominator); end
    req_valid = '0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic test_fairness();
    int fn[5], fd[5], eid[5];
    int got, ngr, cyc;
    logic [NR-1:0] gr;
    bit rearmed;
    fn = '{1000, -3000, 65280, 2048, 1234};
    fd = '{3, 7, -5, 9, -11};
    eid = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NR; i++) put_req(i, NW'(fn[i]), DW'(fd[i]));
    resp_ready = 1'b1; got = 0; ngr = 0; cyc = 0; rearmed = 0;
    while (got < 5 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      gr = req_ready;
      if (gr != '0) begin
        ngr++;
        checks++; if (!$onehot(gr)) begin errors++; $display("FAIL fair_onehot got %b", gr); end
      end
      if (resp_valid) begin
        checks++; if (resp_id !== 2'(eid[got])) begin errors++;
          $display("FAIL fair_id[%0d] got %0d exp %0d", got, resp_id, eid[got]); end
        checks++; if (resp_quotient !== ref_quot(NW'(fn[got]), DW'(fd[got])) || resp_err !== 1'b0) begin errors++;
          $display("FAIL fair_q[%0d] got %h/%b exp %h/0", got, resp_quotient, resp_err, ref_quot(NW'(fn[got]), DW'(fd[got]))); end
        got++;
      end
      @(posedge clk); #1;
      req_valid &= ~gr;
      if (gr[0] && !rearmed) begin put_req(0, NW'(fn[4]), DW'(fd[4])); rearmed = 1; end
    end
    resp_ready = 1'b0;
    checks++; if (got != 5 || ngr != 5) begin errors++;
      $display("FAIL fair_count got resp %0d grants %0d exp 5/5", got, ngr); end
  endtask

  task automatic test_single();
    int cyc, st, sc, g; logic [NR-1:0] gm;
    put_req(2, NW'(65280), DW'(7));
    wait_resp(60, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin errors++;
      $display("FAIL single_id got v%b id%0d exp v1 id2", resp_valid, resp_id); end
    checks++; if (resp_quotient !== 17'd9325 || resp_err !== 1'b0) begin errors++;
      $display("FAIL single_q got %0d/%b exp 9325/0", resp_quotient, resp_err); end
    checks++; if (st != 1 || g != 1 || gm !== 4'b0100) begin errors++;
      $display("FAIL single_hs got starts %0d grants %0d mask %b exp 1/1/0100", st, g, gm); end
    ack();
  endtask

  task automatic test_div_zero();
    int cyc, st, sc, g; logic [NR-1:0] gm;
    put_req(1, NW'(2048), DW'(0));
    wait_resp(30, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_quotient !== 17'h0FFFF || resp_err !== 1'b1) begin
      errors++; $display("FAIL dz_pos got v%b id%0d q%h e%b exp v1 id1 q0ffff e1", resp_valid, resp_id, resp_quotient, resp_err); end
    checks++; if (st != 0) begin errors++; $display("FAIL dz_pos_start got %0d exp 0", st); end
    ack();
    put_req(1, NW'(-1024), DW'(0));
    wait_resp(30, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_quotient !== 17'h10000 || resp_err !== 1'b1) begin
      errors++; $display("FAIL dz_neg got v%b q%h e%b exp v1 q10000 e1", resp_valid, resp_quotient, resp_err); end
    checks++; if (st != 0) begin errors++; $display("FAIL dz_neg_start got %0d exp 0", st); end
    ack();
  endtask

  task automatic test_backpressure();
    int cyc, st, sc, g, bad; logic [NR-1:0] gm;
    put_req(0, NW'(5000), DW'(13));
    wait_resp(60, cyc, st, sc, g, gm);
    put_req(3, NW'(700), DW'(6));
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_quotient !== ref_quot(NW'(5000), DW'(13))) begin
      errors++; $display("FAIL bp_first got v%b id%0d q%0d exp v1 id0 q384", resp_valid, resp_id, resp_quotient); end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_quotient !== 17'd384 || resp_err !== 1'b0 ||
          req_ready !== '0 || div_start !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable got %0d bad cycles exp 0", bad); end
    ack();
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0 || req_ready !== 4'b1000) begin errors++;
      $display("FAIL bp_release got v%b rdy%b exp v0 rdy1000", resp_valid, req_ready); end
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_resp(60, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_quotient !== ref_quot(NW'(700), DW'(6))) begin
      errors++; $display("FAIL bp_second got v%b id%0d q%0d exp v1 id3 q116", resp_valid, resp_id, resp_quotient); end
    ack();
  endtask

  task automatic test_timeout();
    int cyc, st, sc, g, lat; logic [NR-1:0] gm;
    mode = 1;
    put_req(0, NW'(256), DW'(3));
    wait_resp(TO + 40, cyc, st, sc, g, gm);
    lat = cyc - sc;
    checks++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_quotient !== '0) begin errors++;
      $display("FAIL timeout_resp got v%b e%b q%h exp v1 e1 q0", resp_valid, resp_err, resp_quotient); end
    checks++; if (st != 1 || lat < TO || lat > TO + 3) begin errors++;
      $display("FAIL timeout_lat got %0d cycles (starts %0d) exp %0d..%0d", lat, st, TO, TO + 3); end
    ack();
    mode = 0;
  endtask

  task automatic test_stale_done();
    int cyc, st, sc, g; logic [NR-1:0] gm;
    mode = 2;
    put_req(1, NW'(1000), DW'(3));
    wait_resp(60, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_quotient !== 17'd333 || resp_err !== 1'b0) begin errors++;
      $display("FAIL stale_first got v%b q%0d e%b exp v1 q333 e0", resp_valid, resp_quotient, resp_err); end
    ack();
    put_req(2, NW'(5000), DW'(-7));
    wait_resp(60, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_quotient !== ref_quot(NW'(5000), DW'(-7)) ||
                  resp_err !== 1'b0) begin errors++;
      $display("FAIL stale_second got v%b id%0d q%h exp id2 q%h", resp_valid, resp_id, resp_quotient, ref_quot(NW'(5000), DW'(-7))); end
    ack();
    mode = 0;
  endtask

  task automatic test_mid_reset();
    int c, cyc, st, sc, g; bit seen; logic [NR-1:0] gr, gm;
    put_req(2, NW'(3000), DW'(5));
    seen = 0; c = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (div_start) seen = 1;
      if (req_ready != '0) begin gr = req_ready; @(posedge clk); #1 req_valid &= ~gr; end
    end
    repeat (2) @(negedge clk);
    checks++; if (!seen || div_numerator !== 17'd3000) begin errors++;
      $display("FAIL mid_pre got seen%0d num%0d exp 1/3000", seen, div_numerator); end
    reset_n = 1'b0;
    for (int i = 0; i < NR; i++) put_req(i, NW'(400 * (i + 1)), DW'(i + 3));
    #1;
    checks++; if ({req_ready, resp_valid, div_start, resp_err} !== '0 ||
                  {resp_id, resp_quotient, div_numerator, div_denominator} !== '0) begin errors++;
      $display("FAIL mid_async got rdy%b v%b s%b num%h exp all 0", req_ready, resp_valid, div_start, div_numerator); end
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b exp 0001", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    wait_resp(60, cyc, st, sc, g, gm);
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_quotient !== ref_quot(NW'(400), DW'(3))) begin
      errors++; $display("FAIL mid_resp got v%b id%0d q%0d exp v1 id0 q133", resp_valid, resp_id, resp_quotient); end
    ack();
  endtask

  task automatic test_random();
    int m_ptr, n, got, gi, cyc, last, idx;
    int eid[4]; logic [OW-1:0] eq[4]; logic ee[4];
    logic [NR-1:0] mask, gr;
    logic [NW-1:0] rn; logic [DW-1:0] rd;
    do_reset();
    m_ptr = 0;
    for (int round = 0; round < 25; round++) begin
      mask = NR'($urandom_range(1, 15));
      n = 0; last = 0;
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (mask[idx]) begin
          rn = NW'($urandom);
          rd = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom);
          put_req(idx, rn, rd);
          eid[n] = idx; eq[n] = ref_quot(rn, rd); ee[n] = (rd == '0); n++; last = idx;
        end
      end
      m_ptr = (last + 1) % NR;
      got = 0; gi = 0; cyc = 0;
      while (got < n && cyc < 400) begin
        @(negedge clk);
        cyc++;
        gr = req_ready;
        if (gr != '0) begin
          checks++;
          if (gi >= n) begin errors++; $display("FAIL rnd_extra_grant got %b", gr); end
          else if (gr !== (NR'(1) << eid[gi])) begin errors++;
            $display("FAIL rnd_grant r%0d got %b exp id %0d", round, gr, eid[gi]); end
          gi++;
        end
        if (resp_valid && resp_ready) begin
          checks++;
          if (resp_id !== 2'(eid[got]) || resp_quotient !== eq[got] || resp_err !== ee[got]) begin errors++;
            $display("FAIL rnd_resp r%0d got id%0d q%h e%b exp id%0d q%h e%b", round, resp_id,
                     resp_quotient, resp_err, eid[got], eq[got], ee[got]); end
          got++;
        end
        @(posedge clk); #1;
        req_valid &= ~gr;
        resp_ready = ($urandom_range(0, 2) != 0);
      end
      resp_ready = 1'b0;
      checks++; if (got != n) begin errors++; $display("FAIL rnd_count r%0d got %0d exp %0d", round, got, n); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_num = '0; req_den = '0; resp_ready = 1'b0;
    test_reset();
    test_fairness();
    test_single();
    test_div_zero();
    test_backpressure();
    test_timeout();
    test_stale_done();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
